// File: rtl/regfile_pkg.sv
// Shared types and default widths for the register-file write path.
// Also holds the round-robin pointer encoding used by the arbiter.
package regfile_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_idx_t  dest;
    reg_data_t data;
  } wr_req_t;

  typedef enum logic {
    PTR_REQ0 = 1'b0,
    PTR_REQ1 = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, pointer advances past each winner.
// Reusable wherever two requesters share one port.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  rr_ptr_e ptr_q;
  rr_ptr_e ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PTR_REQ0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // The pointer names the requester that wins a tie on the next contention.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_o[0]) begin
      ptr_d = PTR_REQ1;
    end else if (gnt_o[1]) begin
      ptr_d = PTR_REQ0;
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_comb begin
    gnt_o = 2'b00;
    if (rst || !en_i) begin
      gnt_o = 2'b00;
    end else begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (ptr_q == PTR_REQ0) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU writeback and the load/immediate unit.
// The winning write is held in a one-entry stage that also publishes a pending-write mask.
module regfile_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0Valid_i,
  input  logic [ADDR_W-1:0]    req0Dest_i,
  input  logic [DATA_W-1:0]    req0Data_i,
  output logic                 req0Ready_o,
  input  logic                 req1Valid_i,
  input  logic [ADDR_W-1:0]    req1Dest_i,
  input  logic [DATA_W-1:0]    req1Data_i,
  output logic                 req1Ready_o,
  input  logic                 stall_i,
  output logic [ADDR_W-1:0]    destReg_o,
  output logic [DATA_W-1:0]    data_o,
  output logic                 writeFlag_o,
  output logic [2**ADDR_W-1:0] pendingMask_o
);

  import regfile_pkg::*;

  localparam int NREG = 2**ADDR_W;

  logic [1:0]        gnt_s;
  logic              flag_q;
  logic              flag_d;
  logic [ADDR_W-1:0] dest_q;
  logic [ADDR_W-1:0] dest_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [NREG-1:0]   mask_q;
  logic [NREG-1:0]   mask_d;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({req1Valid_i, req0Valid_i}),
    .en_i  (!stall_i),
    .gnt_o (gnt_s)
  );

  assign req0Ready_o = gnt_s[0];
  assign req1Ready_o = gnt_s[1];

  // Dest/data only move on a grant, so an idle requester's bus never reaches the stage.
  always_comb begin
    flag_d = flag_q;
    dest_d = dest_q;
    data_d = data_q;
    if (stall_i) begin
      flag_d = flag_q;
    end else if (gnt_s[0]) begin
      flag_d = 1'b1;
      dest_d = req0Dest_i;
      data_d = req0Data_i;
    end else if (gnt_s[1]) begin
      flag_d = 1'b1;
      dest_d = req1Dest_i;
      data_d = req1Data_i;
    end else begin
      flag_d = 1'b0;
    end
  end

  always_comb begin
    mask_d = '0;
    if (flag_d) begin
      mask_d[dest_d] = 1'b1;
    end else begin
      mask_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      flag_q <= flag_d;
      dest_q <= dest_d;
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end

  assign writeFlag_o   = flag_q;
  assign destReg_o     = dest_q;
  assign data_o        = data_q;
  assign pendingMask_o = mask_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with hand-computed expectations.
module tb_regfile_write_arbiter;

  logic       clk;
  logic       rst;
  logic       req0Valid_i;
  logic [2:0] req0Dest_i;
  logic [7:0] req0Data_i;
  logic       req0Ready_o;
  logic       req1Valid_i;
  logic [2:0] req1Dest_i;
  logic [7:0] req1Data_i;
  logic       req1Ready_o;
  logic       stall_i;
  logic [2:0] destReg_o;
  logic [7:0] data_o;
  logic       writeFlag_o;
  logic [7:0] pendingMask_o;

  int n_pass  = 0;
  int n_total = 0;

  regfile_write_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0Valid_i   (req0Valid_i),
    .req0Dest_i    (req0Dest_i),
    .req0Data_i    (req0Data_i),
    .req0Ready_o   (req0Ready_o),
    .req1Valid_i   (req1Valid_i),
    .req1Dest_i    (req1Dest_i),
    .req1Data_i    (req1Data_i),
    .req1Ready_o   (req1Ready_o),
    .stall_i       (stall_i),
    .destReg_o     (destReg_o),
    .data_o        (data_o),
    .writeFlag_o   (writeFlag_o),
    .pendingMask_o (pendingMask_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    #2;
    chk({tag, "_rdy0"}, {31'd0, req0Ready_o}, {31'd0, r0});
    chk({tag, "_rdy1"}, {31'd0, req1Ready_o}, {31'd0, r1});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stage(input string tag, input logic f, input logic [2:0] d,
                           input logic [7:0] x, input logic [7:0] m);
    chk({tag, "_flag"}, {31'd0, writeFlag_o}, {31'd0, f});
    chk({tag, "_dest"}, {29'd0, destReg_o}, {29'd0, d});
    chk({tag, "_data"}, {24'd0, data_o}, {24'd0, x});
    chk({tag, "_mask"}, {24'd0, pendingMask_o}, {24'd0, m});
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0;
    req0Valid_i = 1'b1; req0Dest_i = 3'd1; req0Data_i = 8'h11;
    req1Valid_i = 1'b1; req1Dest_i = 3'd2; req1Data_i = 8'h22;

    // reset held two cycles with both requesters valid
    for (int i = 0; i < 2; i++) begin
      step();
      chk_rdy("reset", 1'b0, 1'b0);
      chk_stage("reset", 1'b0, 3'd0, 8'h00, 8'h00);
    end

    // lone req0 write
    rst = 1'b0;
    req1Valid_i = 1'b0;
    req0Dest_i = 3'd3; req0Data_i = 8'hA5;
    chk_rdy("single", 1'b1, 1'b0);
    step();
    chk_stage("single", 1'b1, 3'd3, 8'hA5, 8'h08);

    // idle with garbage buses: nothing reaches the stage
    req0Valid_i = 1'b0; req0Dest_i = 3'd7; req0Data_i = 8'hFF;
    req1Dest_i = 3'd6; req1Data_i = 8'hEE;
    chk_rdy("idle", 1'b0, 1'b0);
    step();
    chk_stage("idle", 1'b0, 3'd3, 8'hA5, 8'h00);

    // same destination, pointer at req1 after the req0 grant
    req0Valid_i = 1'b1; req0Dest_i = 3'd5; req0Data_i = 8'h50;
    req1Valid_i = 1'b1; req1Dest_i = 3'd5; req1Data_i = 8'h51;
    chk_rdy("samedst_a", 1'b0, 1'b1);
    step();
    chk_stage("samedst_a", 1'b1, 3'd5, 8'h51, 8'h20);
    req1Valid_i = 1'b0;
    chk_rdy("samedst_b", 1'b1, 1'b0);
    step();
    chk_stage("samedst_b", 1'b1, 3'd5, 8'h50, 8'h20);

    // contention: pointer at req1, grants alternate req1, req0, ...
    req0Dest_i = 3'd1; req0Data_i = 8'h11;
    req1Valid_i = 1'b1; req1Dest_i = 3'd2; req1Data_i = 8'h22;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        chk_rdy("contend", 1'b0, 1'b1);
        step();
        chk_stage("contend", 1'b1, 3'd2, 8'h22, 8'h04);
      end else begin
        chk_rdy("contend", 1'b1, 1'b0);
        step();
        chk_stage("contend", 1'b1, 3'd1, 8'h11, 8'h02);
      end
    end

    // stall three cycles with req1 waiting; stage frozen on the last req0 write
    req0Valid_i = 1'b0;
    req1Dest_i = 3'd6; req1Data_i = 8'h66;
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_rdy("stall", 1'b0, 1'b0);
      step();
      chk_stage("stall", 1'b1, 3'd1, 8'h11, 8'h02);
    end
    stall_i = 1'b0;
    chk_rdy("unstall", 1'b0, 1'b1);
    step();
    chk_stage("unstall", 1'b1, 3'd6, 8'h66, 8'h40);

    // mid-operation reset: grant req0, reset next cycle, pointer returns to req0
    req1Valid_i = 1'b0;
    req0Valid_i = 1'b1; req0Dest_i = 3'd4; req0Data_i = 8'h44;
    chk_rdy("pre_rst", 1'b1, 1'b0);
    step();
    chk_stage("pre_rst", 1'b1, 3'd4, 8'h44, 8'h10);
    rst = 1'b1;
    req1Valid_i = 1'b1; req1Dest_i = 3'd2; req1Data_i = 8'h22;
    req0Dest_i = 3'd1; req0Data_i = 8'h11;
    chk_rdy("mid_rst", 1'b0, 1'b0);
    step();
    chk_stage("mid_rst", 1'b0, 3'd0, 8'h00, 8'h00);
    rst = 1'b0;
    chk_rdy("post_rst", 1'b1, 1'b0);
    step();
    chk_stage("post_rst", 1'b1, 3'd1, 8'h11, 8'h02);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
